// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient} for HI/LO.
// Optional macro DIV_BY_ZERO_FLAG_EN adds a div_zero flag that accompanies ready.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
`ifdef DIV_BY_ZERO_FLAG_EN
    output logic               div_zero,
`endif
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, DZERO, ON, END} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic               dz_q, dz_d;
`endif

    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   step_rem, step_quot;
    logic               last_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic use_sign);
        return (use_sign && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // One restoring step: the dividend shift register also collects quotient bits.
    always_comb begin
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        step_rem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        step_quot = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        result_d   = result_q;
`ifdef DIV_BY_ZERO_FLAG_EN
        dz_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    busy_d = 1'b1;
                    if (opdata2 == '0) begin
                        state_d = DZERO;
                    end else begin
                        state_d    = ON;
                        neg_quot_d = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_rem_d  = signed_div && opdata1[WIDTH-1];
                        dvd_d      = magnitude($signed(opdata1), signed_div);
                        dvs_d      = magnitude($signed(opdata2), signed_div);
                        rem_d      = '0;
                        cnt_d      = '0;
                    end
                end
            end
            DZERO: begin
                busy_d = 1'b0;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = '0;
`ifdef DIV_BY_ZERO_FLAG_EN
                    dz_d     = 1'b1;
`endif
                end
            end
            ON: begin
                if (annul) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = step_rem;
                    dvd_d = step_quot;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Result is sign-corrected as it is registered, so it is valid while in END.
                    if (last_step) begin
                        state_d  = END;
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                        result_d = {apply_sign(step_rem, neg_rem_q),
                                    apply_sign(step_quot, neg_quot_q)};
                    end
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
`ifdef DIV_BY_ZERO_FLAG_EN
            dz_q       <= dz_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = result_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    assign div_zero = dz_q;
`endif

endmodule
